// File: rtl/led_seq_pkg.sv
// Shared types for the LED sequencer: display modes, sweep direction and the
// width of the rate selector.
package led_seq_pkg;

  localparam int RATE_W = 4;

  typedef enum logic [1:0] {
    BINARY  = 2'd0,
    BOUNCE  = 2'd1,
    BREATHE = 2'd2,
    STATIC  = 2'd3
  } mode_t;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_t;

endpackage

// File: rtl/led_prescaler.sv
// Free-running prescaler producing one raw tick per 2^(BASE_SHIFT+rate_sel)
// clocks, with pause freezing the count and step forcing a tick while paused.
module led_prescaler
  import led_seq_pkg::*;
#(
  parameter int BASE_SHIFT = 18,
  parameter int PRESC_W    = 34
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [RATE_W-1:0] rate_sel,
  input  logic              pause,
  input  logic              step,
  output logic              raw_tick
);

  logic [PRESC_W-1:0] presc_q;
  logic [PRESC_W-1:0] presc_d;
  logic [PRESC_W-1:0] mask;

  always_comb begin
    presc_d = presc_q;
    if (!pause) begin
      presc_d = presc_q + 1'b1;
    end
  end

  // The mask follows rate_sel combinationally, so a rate change takes effect
  // on the very next cycle without clearing the count.
  always_comb begin
    mask = '0;
    for (int i = 0; i < PRESC_W; i++) begin
      mask[i] = (i < (BASE_SHIFT + int'(rate_sel)));
    end
  end

  always_comb begin
    if (pause) begin
      raw_tick = step;
    end else begin
      raw_tick = ((presc_q & mask) == mask);
    end
  end

  // NOTE: sequential state is always updated with non-blocking assignments so
  // every flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

endmodule

// File: rtl/led_sequencer.sv
// LED activity driver: binary count, bounce, PWM breathe or static pattern,
// advanced by the prescaler tick; leds and tick are registered outputs.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int N_LEDS     = 10,
  parameter int BASE_SHIFT = 18,
  parameter int PRESC_W    = 34,
  parameter int PWM_W      = 8
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  mode_t             mode,
  input  logic [RATE_W-1:0] rate_sel,
  input  logic              pause,
  input  logic              step,
  input  logic [N_LEDS-1:0] pattern_in,
  output logic [N_LEDS-1:0] leds,
  output logic              tick
);

  localparam int              POS_W   = $clog2(N_LEDS);
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(N_LEDS - 1);
  localparam logic [PWM_W-1:0] LVL_MAX = '1;

  logic raw_tick;
  logic mode_chg;

  mode_t             mode_q;
  logic [N_LEDS-1:0] value_q,   value_d;
  logic [POS_W-1:0]  pos_q,     pos_d;
  dir_t              dir_q,     dir_d;
  logic [PWM_W-1:0]  level_q,   level_d;
  logic [PWM_W-1:0]  pwm_cnt_q, pwm_cnt_d;
  logic [N_LEDS-1:0] leds_q,    leds_d;
  logic              tick_q,    tick_d;

  led_prescaler #(
    .BASE_SHIFT (BASE_SHIFT),
    .PRESC_W    (PRESC_W)
  ) u_prescaler (
    .clk      (CLOCK_50),
    .reset    (reset),
    .rate_sel (rate_sel),
    .pause    (pause),
    .step     (step),
    .raw_tick (raw_tick)
  );

  assign mode_chg = (mode != mode_q);

  // NOTE: every variable assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    value_d = value_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    level_d = level_q;
    if (mode_chg) begin
      // A tick landing on the mode-change cycle is deliberately dropped.
      value_d = '0;
      pos_d   = '0;
      dir_d   = UP;
      level_d = '0;
    end else if (raw_tick) begin
      unique case (mode_q)
        BINARY: value_d = value_q + 1'b1;
        BOUNCE: begin
          if (dir_q == UP) begin
            if (pos_q == POS_MAX) begin
              pos_d = POS_MAX - 1'b1;
              dir_d = DOWN;
            end else begin
              pos_d = pos_q + 1'b1;
            end
          end else begin
            if (pos_q == '0) begin
              pos_d = POS_W'(1);
              dir_d = UP;
            end else begin
              pos_d = pos_q - 1'b1;
            end
          end
        end
        BREATHE: begin
          if (dir_q == UP) begin
            if (level_q == LVL_MAX) begin
              level_d = LVL_MAX - 1'b1;
              dir_d   = DOWN;
            end else begin
              level_d = level_q + 1'b1;
            end
          end else begin
            if (level_q == '0) begin
              level_d = PWM_W'(1);
              dir_d   = UP;
            end else begin
              level_d = level_q - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // leds is decoded from next-state values so it moves on the same edge as
  // the state it displays, keeping it aligned with the tick output.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    tick_d    = raw_tick;
    unique case (mode)
      BINARY:  leds_d = value_d;
      BOUNCE:  leds_d = N_LEDS'(1) << pos_d;
      BREATHE: leds_d = {N_LEDS{(pwm_cnt_d < level_d)}};
      STATIC:  leds_d = pattern_in;
      default: leds_d = '0;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      mode_q <= BINARY;
    end else begin
      mode_q <= mode;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      value_q <= '0;
      pos_q   <= '0;
      dir_q   <= UP;
      level_q <= '0;
    end else begin
      value_q <= value_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      leds_q <= '0;
      tick_q <= 1'b0;
    end else begin
      leds_q <= leds_d;
      tick_q <= tick_d;
    end
  end

  assign leds = leds_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer with a fast prescaler and 4 LEDs; all
// expected values are hand-computed constants.
module tb_led_sequencer;
  import led_seq_pkg::*;

  localparam int N_LEDS     = 4;
  localparam int BASE_SHIFT = 2;
  localparam int PRESC_W    = 34;
  localparam int PWM_W      = 4;

  logic              clk = 1'b0;
  logic              reset;
  mode_t             mode;
  logic [RATE_W-1:0] rate_sel;
  logic              pause;
  logic              step;
  logic [N_LEDS-1:0] pattern_in;
  logic [N_LEDS-1:0] leds;
  logic              tick;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  led_sequencer #(
    .N_LEDS     (N_LEDS),
    .BASE_SHIFT (BASE_SHIFT),
    .PRESC_W    (PRESC_W),
    .PWM_W      (PWM_W)
  ) dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .mode       (mode),
    .rate_sel   (rate_sel),
    .pause      (pause),
    .step       (step),
    .pattern_in (pattern_in),
    .leds       (leds),
    .tick       (tick)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for the next tick, returning the negedges elapsed.
  task automatic wait_tick(input int limit, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!tick && cycles < limit);
    check("tick_seen", 32'(tick), 32'd1);
  endtask

  task automatic pulse_step();
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
  endtask

  logic [3:0] bnc_exp [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};

  initial begin
    int cyc;
    int on_cnt;
    int bad_cnt;
    int tick_cnt;

    reset      = 1'b1;
    mode       = BINARY;
    rate_sel   = '0;
    pause      = 1'b0;
    step       = 1'b0;
    pattern_in = '0;

    // 1: reset state, then binary count with a 4-clock tick and wrap
    repeat (2) @(negedge clk);
    check("rst_leds", 32'(leds), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    reset = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      wait_tick(64, cyc);
      check("bin_period", 32'(cyc), 32'd4);
      check("bin_leds", 32'(leds), 32'(i % 16));
    end

    // 2: bounce at rate_sel=1 (8-clock spacing)
    mode     = BOUNCE;
    rate_sel = 4'd1;
    @(negedge clk);
    check("bnc_start", 32'(leds), 32'b0001);
    for (int i = 0; i < 7; i++) begin
      wait_tick(64, cyc);
      if (i > 0) check("bnc_period", 32'(cyc), 32'd8);
      check("bnc_leds", 32'(bnc_exp[i]), 32'(leds));
    end

    // 3: breathe, level 0 fully off, then level 5 on for 5 of 16 clocks
    mode  = BREATHE;
    pause = 1'b1;
    @(negedge clk);
    on_cnt  = 0;
    bad_cnt = 0;
    repeat (16) begin
      @(negedge clk);
      if (leds == 4'hF) on_cnt++;
      else if (leds != 4'h0) bad_cnt++;
    end
    check("brt_off", 32'(on_cnt), 32'd0);
    pause = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_tick(64, cyc);
    end
    pause = 1'b1;
    on_cnt = 0;
    repeat (16) begin
      @(negedge clk);
      if (leds == 4'hF) on_cnt++;
      else if (leds != 4'h0) bad_cnt++;
    end
    check("brt_lvl5", 32'(on_cnt), 32'd5);
    check("brt_mixed", 32'(bad_cnt), 32'd0);

    // 4: paused for 100 clocks, then three single steps
    mode = BINARY;
    @(negedge clk);
    check("pause_clr", 32'(leds), 32'd0);
    tick_cnt = 0;
    bad_cnt  = 0;
    repeat (100) begin
      @(negedge clk);
      if (tick) tick_cnt++;
      if (leds != 4'h0) bad_cnt++;
    end
    check("pause_tick", 32'(tick_cnt), 32'd0);
    check("pause_leds", 32'(bad_cnt), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      pulse_step();
      check("step_tick", 32'(tick), 32'd1);
      check("step_leds", 32'(leds), 32'(k));
      @(negedge clk);
      check("step_tick_clr", 32'(tick), 32'd0);
      check("step_hold", 32'(leds), 32'(k));
    end

    // 5: binary at 7 -> static -> back to binary with a coincident step
    repeat (4) pulse_step();
    check("bin7", 32'(leds), 32'd7);
    mode       = STATIC;
    pattern_in = 4'b1010;
    @(negedge clk);
    check("static", 32'(leds), 32'b1010);
    pattern_in = 4'b0110;
    @(negedge clk);
    check("static_live", 32'(leds), 32'b0110);
    mode = BINARY;
    pulse_step();
    check("modechg_drop", 32'(leds), 32'd0);
    pulse_step();
    check("bin_restart", 32'(leds), 32'd1);

    // 6: reset in the middle of a bounce, then resume from pos 0 going up
    mode = BOUNCE;
    @(negedge clk);
    check("bnc6_start", 32'(leds), 32'b0001);
    repeat (2) pulse_step();
    check("bnc6_pos2", 32'(leds), 32'b0100);
    reset = 1'b1;
    step  = 1'b1;
    @(negedge clk);
    check("rst_mid_leds", 32'(leds), 32'd0);
    check("rst_mid_tick", 32'(tick), 32'd0);
    reset    = 1'b0;
    step     = 1'b0;
    pause    = 1'b0;
    rate_sel = '0;
    @(negedge clk);
    check("rst_rel_leds", 32'(leds), 32'b0001);
    wait_tick(64, cyc);
    check("rst_rel_period", 32'(cyc), 32'd3);
    check("rst_rel_pos1", 32'(leds), 32'b0010);
    wait_tick(64, cyc);
    check("rst_rel_period2", 32'(cyc), 32'd4);
    check("rst_rel_pos2", 32'(leds), 32'b0100);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule
